// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the matrix-transfer UART receiver
package uart_pkg;

  localparam int ROWS = 2;
  localparam int COLS = 4;

  localparam logic [1:0] MODE_CELL = 2'd1;
  localparam logic [1:0] MODE_ROW  = 2'd2;
  localparam logic [1:0] MODE_COL  = 2'd3;

  // Header byte layout: [1:0] mode, [2] row, [4:3] col, [7:5] reserved-zero
  localparam int HDR_MODE_LSB = 0;
  localparam int HDR_ROW_BIT  = 2;
  localparam int HDR_COL_LSB  = 3;
  localparam int HDR_RSV_LSB  = 5;

  typedef enum logic [2:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_PARITY,
    B_STOP
  } byte_state_e;

  typedef enum logic {
    F_HDR,
    F_PAY
  } frame_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - rx synchroniser and byte deserialiser; UART_RX_PARITY_EN adds an even-parity bit
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  byte_state_e   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= B_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      B_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = B_START;
      end
      B_START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = sync2_q ? B_IDLE : B_DATA;
        end
      end
      B_DATA: begin
        if (cnt_q == FULL) begin
          cnt_d  = '0;
          data_d = {sync2_q, data_q[7:1]};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = B_PARITY;
`else
            state_d = B_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      B_PARITY: begin
        if (cnt_q == FULL) begin
          cnt_d = '0;
          if (^{data_q, sync2_q}) begin
            ferr_d  = 1'b1;
            state_d = B_IDLE;
          end else begin
            state_d = B_STOP;
          end
        end
      end
`endif
      B_STOP: begin
        if (cnt_q == FULL) begin
          state_d = B_IDLE;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end
      end
      default: state_d = B_IDLE;
    endcase
  end

  assign byte_data  = data_q;
  assign byte_valid = valid_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != B_IDLE);

endmodule

// File: rtl/uart_matrix_rx.sv
// rtl/uart_matrix_rx.sv - frame decoder writing received words into a 2x4 matrix; UART_RX_PARITY_EN selects 8E1 bytes
module uart_matrix_rx
  import uart_pkg::*;
#(
  parameter int W            = 32,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  input  logic         row,
  input  logic [1:0]   col,
  output logic [W-1:0] r_cell,
  output logic         r_busy,
  output logic         done,
  output logic         err
);

  localparam int BYTES = W / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [7:0] byte_data;
  logic       byte_valid, frame_err, byte_busy;

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .byte_data  (byte_data),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .busy       (byte_busy)
  );

  frame_state_e   fstate_q, fstate_d;
  logic [1:0]     mode_q, mode_d;
  logic           hrow_q, hrow_d;
  logic [1:0]     hcol_q, hcol_d;
  logic [W-1:0]   word_q, word_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic [1:0]     wcnt_q, wcnt_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [W-1:0]   mat_q [ROWS][COLS];

  logic [W-1:0]   asm_word;
  logic           wr_en, wr_row, last_word;
  logic [1:0]     wr_col;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fstate_q <= F_HDR;
      mode_q   <= '0;
      hrow_q   <= 1'b0;
      hcol_q   <= '0;
      word_q   <= '0;
      bcnt_q   <= '0;
      wcnt_q   <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          mat_q[r][c] <= '0;
    end else begin
      fstate_q <= fstate_d;
      mode_q   <= mode_d;
      hrow_q   <= hrow_d;
      hcol_q   <= hcol_d;
      word_q   <= word_d;
      bcnt_q   <= bcnt_d;
      wcnt_q   <= wcnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      if (wr_en) mat_q[wr_row][wr_col] <= asm_word;
    end
  end

  // Target cell for the word being assembled, by transfer mode
  always_comb begin
    wr_row    = hrow_q;
    wr_col    = hcol_q;
    last_word = 1'b1;
    case (mode_q)
      MODE_ROW: begin
        wr_col    = wcnt_q;
        last_word = (wcnt_q == 2'(COLS - 1));
      end
      MODE_COL: begin
        wr_row    = wcnt_q[0];
        last_word = (wcnt_q == 2'(ROWS - 1));
      end
      default: ;
    endcase
  end

  always_comb begin
    fstate_d = fstate_q;
    mode_d   = mode_q;
    hrow_d   = hrow_q;
    hcol_d   = hcol_q;
    word_d   = word_q;
    bcnt_d   = bcnt_q;
    wcnt_d   = wcnt_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    wr_en    = 1'b0;
    asm_word = word_q;
    for (int k = 0; k < BYTES; k++)
      if (bcnt_q == BCW'(k)) asm_word[8*k +: 8] = byte_data;

    if (frame_err) begin
      err_d    = 1'b1;
      fstate_d = F_HDR;
    end else if (byte_valid) begin
      if (fstate_q == F_HDR) begin
        if (byte_data[HDR_MODE_LSB +: 2] == 2'd0 || byte_data[HDR_RSV_LSB +: 3] != 3'd0) begin
          err_d = 1'b1;
        end else begin
          mode_d   = byte_data[HDR_MODE_LSB +: 2];
          hrow_d   = byte_data[HDR_ROW_BIT];
          hcol_d   = byte_data[HDR_COL_LSB +: 2];
          word_d   = '0;
          bcnt_d   = '0;
          wcnt_d   = '0;
          fstate_d = F_PAY;
        end
      end else begin
        word_d = asm_word;
        if (bcnt_q == BCW'(BYTES - 1)) begin
          wr_en  = 1'b1;
          bcnt_d = '0;
          wcnt_d = wcnt_q + 2'd1;
          if (last_word) begin
            done_d   = 1'b1;
            fstate_d = F_HDR;
          end
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
    end
  end

  assign r_cell = mat_q[row][col];
  assign r_busy = byte_busy || (fstate_q == F_PAY);
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_uart_matrix_rx.sv
// tb/tb_uart_matrix_rx.sv - directed vectors for uart_matrix_rx; UART_RX_PARITY_EN enables the parity cases
module tb_uart_matrix_rx;

  localparam int W   = 32;
  localparam int CPB = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         rx  = 1'b1;
  logic         row = 1'b0;
  logic [1:0]   col = 2'd0;
  logic [W-1:0] r_cell;
  logic         r_busy, done, err;

  uart_matrix_rx #(.W(W), .CLKS_PER_BIT(CPB)) dut (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .row    (row),
    .col    (col),
    .r_cell (r_cell),
    .r_busy (r_busy),
    .done   (done),
    .err    (err)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (done && err) both_cnt++;
    end
  end

  typedef struct packed {
    logic [7:0]       hdr;
    logic [2:0]       nwords;
    logic             exp_err;
    logic [3:0][31:0] words;
    logic [7:0][31:0] exp;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic bit_period(input logic v);
    @(posedge clk);
    #1 rx = v;
    repeat (CPB - 1) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_stop, input logic bad_par);
    logic stop_v;
    stop_v = !bad_stop;
    bit_period(1'b0);
    for (int i = 0; i < 8; i++) bit_period(b[i]);
`ifdef UART_RX_PARITY_EN
    bit_period(^b ^ bad_par);
`else
    if (bad_par) stop_v = 1'b0;
`endif
    bit_period(stop_v);
    bit_period(1'b1);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic settle();
    repeat (4) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all(input logic [7:0][31:0] expm, input string tag);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++) begin
        row = r[0];
        col = c[1:0];
        #1;
        chk($sformatf("%s cell(%0d,%0d)", tag, r, c), r_cell, expm[r*4+c]);
      end
  endtask

  function automatic vec_t mk(input logic [7:0] hdr, input logic [2:0] n, input logic e,
                              input logic [31:0] w0, input logic [31:0] w1,
                              input logic [31:0] w2, input logic [31:0] w3);
    vec_t v;
    v.hdr      = hdr;
    v.nwords   = n;
    v.exp_err  = e;
    v.words[0] = w0;
    v.words[1] = w1;
    v.words[2] = w2;
    v.words[3] = w3;
    v.exp      = '0;
    return v;
  endfunction

  initial begin
    int d0, e0;
    logic [7:0][31:0] em;

    vecs[0] = mk(8'h1D, 3'd1, 1'b0, 32'h00000008, 0, 0, 0);
    vecs[0].exp[7] = 32'h00000008;
    vecs[1] = mk(8'h02, 3'd4, 1'b0, 32'd1, 32'd2, 32'd3, 32'd4);
    vecs[1].exp[0] = 32'd1; vecs[1].exp[1] = 32'd2; vecs[1].exp[2] = 32'd3; vecs[1].exp[3] = 32'd4;
    vecs[2] = mk(8'h13, 3'd2, 1'b0, 32'h55555555, 32'hAAAAAAAA, 0, 0);
    vecs[2].exp[2] = 32'h55555555; vecs[2].exp[6] = 32'hAAAAAAAA;
    vecs[3] = mk(8'h06, 3'd4, 1'b0, 32'h01020304, 32'h0A0B0C0D, 32'hFFFFFFFF, 32'h80000001);
    vecs[3].exp[4] = 32'h01020304; vecs[3].exp[5] = 32'h0A0B0C0D;
    vecs[3].exp[6] = 32'hFFFFFFFF; vecs[3].exp[7] = 32'h80000001;
    vecs[4] = mk(8'h01, 3'd1, 1'b0, 32'hCAFEF00D, 0, 0, 0);
    vecs[4].exp[0] = 32'hCAFEF00D;
    vecs[5] = mk(8'h20, 3'd0, 1'b1, 0, 0, 0, 0);
    vecs[6] = mk(8'h00, 3'd0, 1'b1, 0, 0, 0, 0);

    // Reset state, observed while reset is held
    repeat (2) @(posedge clk);
    #1;
    check_all('0, "reset");
    chk("reset r_busy", {31'd0, r_busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset err", {31'd0, err}, 32'd0);
    #1 rst = 1'b1;

    for (int v = 0; v < 7; v++) begin
      do_reset();
      d0 = done_cnt;
      e0 = err_cnt;
      send_byte(vecs[v].hdr, 1'b0, 1'b0);
      for (int w = 0; w < int'(vecs[v].nwords); w++)
        for (int k = 0; k < 4; k++) begin
          if (w == int'(vecs[v].nwords) - 1 && k == 3)
            chk($sformatf("v%0d done before last byte", v), done_cnt - d0, 0);
          send_byte(vecs[v].words[w][8*k +: 8], 1'b0, 1'b0);
        end
      settle();
      check_all(vecs[v].exp, $sformatf("v%0d", v));
      chk($sformatf("v%0d done count", v), done_cnt - d0, vecs[v].exp_err ? 0 : 1);
      chk($sformatf("v%0d err count", v), err_cnt - e0, vecs[v].exp_err ? 1 : 0);
      chk($sformatf("v%0d r_busy idle", v), {31'd0, r_busy}, 32'd0);
    end

    // Bad header followed by a good cell frame
    do_reset();
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h20, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_word(32'hDEADBEEF);
    settle();
    em = '0; em[0] = 32'hDEADBEEF;
    check_all(em, "hdr-err recover");
    chk("hdr-err err count", err_cnt - e0, 1);
    chk("hdr-err done count", done_cnt - d0, 1);

    // Stop-bit error on the third payload byte of a row frame
    do_reset();
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h02, 1'b0, 1'b0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_byte(8'h00, 1'b0, 1'b0);
    send_byte(8'h00, 1'b1, 1'b0);
    settle();
    check_all('0, "stop-err");
    chk("stop-err err count", err_cnt - e0, 1);
    chk("stop-err done count", done_cnt - d0, 0);
    chk("stop-err r_busy", {31'd0, r_busy}, 32'd0);
    send_byte(8'h01, 1'b0, 1'b0);
    send_word(32'h12345678);
    settle();
    em = '0; em[0] = 32'h12345678;
    check_all(em, "stop-err recover");
    chk("stop-err recover done", done_cnt - d0, 1);

    // Asynchronous reset in the middle of the second word of a row frame
    do_reset();
    send_byte(8'h02, 1'b0, 1'b0);
    send_word(32'h11223344);
    settle();
    row = 1'b0; col = 2'd0; #1;
    chk("midrst first word", r_cell, 32'h11223344);
    send_byte(8'h55, 1'b0, 1'b0);
    bit_period(1'b0);
    bit_period(1'b1);
    bit_period(1'b0);
    chk("midrst busy before", {31'd0, r_busy}, 32'd1);
    #3 rst = 1'b0;
    rx = 1'b1;
    #1;
    chk("midrst r_busy", {31'd0, r_busy}, 32'd0);
    check_all('0, "midrst");
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    d0 = done_cnt;
    send_byte(8'h1D, 1'b0, 1'b0);
    send_word(32'h00000008);
    settle();
    em = '0; em[7] = 32'h00000008;
    check_all(em, "midrst recover");
    chk("midrst recover done", done_cnt - d0, 1);

`ifdef UART_RX_PARITY_EN
    do_reset();
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'h1D, 1'b0, 1'b0);
    send_word(32'hAAAAAAAA);
    settle();
    em = '0; em[7] = 32'hAAAAAAAA;
    check_all(em, "parity ok");
    chk("parity ok done", done_cnt - d0, 1);
    send_byte(8'h1D, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b0);
    send_byte(8'h55, 1'b0, 1'b1);
    settle();
    check_all(em, "parity bad");
    chk("parity bad err", err_cnt - e0, 1);
    chk("parity bad done", done_cnt - d0, 1);
    chk("parity bad r_busy", {31'd0, r_busy}, 32'd0);
`endif

    chk("done and err together", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
